btn_step_counter: RTL and testbench

- Parametrised successor to the board-level button counter.
- Debounces three raw push-button inputs: increment, decrement and clear.
- Drives a WIDTH-bit up/down counter with selectable wrap or saturate mode and hold-to-auto-repeat.
- Sits between the board button pins and the LED/display logic in the top level. Replaces ad-hoc counter logic in the top.

---
 rtl/counter_pkg.sv | 15 +
 rtl/debounce_channel.sv | 37 +++
 rtl/btn_step_counter.sv | 92 +++++++++
 tb/tb_btn_step_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings and helpers for the button step counter
package counter_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronise, normalise and debounce one raw push button
module debounce_channel
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_evt
);
  localparam int CW = clog2(DEBOUNCE_CYCLES);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // two-flop sync, then count disagreeing samples until the new level is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      s1 <= raw ^ ACTIVE_LOW;
      s2 <= s1;
      press_evt <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt <= '0;
        press_evt <= s2;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/btn_step_counter.sv
// btn_step_counter: debounced inc/dec/clear buttons driving an up/down counter with auto-repeat
module btn_step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter bit SATURATE = 1'b0,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc,
  input  logic btn_dec,
  input  logic btn_clr,
  output logic [WIDTH-1:0] count,
  output logic wrap,
  output logic at_max,
  output logic at_min
);
  localparam int TW = clog2(((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic inc_lvl, inc_evt, dec_lvl, dec_evt, clr_level_unused, clr_evt;
  logic [1:0] state;
  logic dir;
  logic [TW-1:0] timer;
  logic lat, oth, keep, done, tick, block, up, dn, roll;
  logic [WIDTH-1:0] count_nxt;
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_inc (
    .clk(clk), .rst_n(rst_n), .raw(btn_inc), .level(inc_lvl), .press_evt(inc_evt)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_dec (
    .clk(clk), .rst_n(rst_n), .raw(btn_dec), .level(dec_lvl), .press_evt(dec_evt)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_clr (
    .clk(clk), .rst_n(rst_n), .raw(btn_clr), .level(clr_level_unused), .press_evt(clr_evt)
  );
  // step arbitration: clear beats everything, both held blocks, then one inc or dec step
  always_comb begin
    lat = (dir == DIR_UP) ? inc_lvl : dec_lvl;
    oth = (dir == DIR_UP) ? dec_lvl : inc_lvl;
    keep = lat & ~oth;
    done = ((state == HOLD) && (timer == TW'(HOLD_CYCLES - 1))) ||
           ((state == REPEAT) && (timer == TW'(REPEAT_CYCLES - 1)));
    tick = keep & done;
    block = clr_evt | (inc_lvl & dec_lvl);
    up = ~block & (inc_evt | (tick & (dir == DIR_UP)));
    dn = ~block & (dec_evt | (tick & (dir == DIR_DOWN)));
    roll = !SATURATE && ((up && (count == MAX)) || (dn && (count == '0)));
    count_nxt = clr_evt ? '0 :
                (up && !(SATURATE && (count == MAX))) ? count + 1'b1 :
                (dn && !(SATURATE && (count == '0))) ? count - 1'b1 : count;
  end
  // repeat FSM: wait HOLD_CYCLES on a lone press, then tick every REPEAT_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir <= DIR_UP;
      timer <= '0;
    end else if (block) begin
      state <= IDLE;
      timer <= '0;
    end else if (state == IDLE) begin
      if ((HOLD_CYCLES != 0) && (inc_evt || dec_evt)) begin
        state <= HOLD;
        timer <= '0;
        dir <= inc_evt ? DIR_UP : DIR_DOWN;
      end
    end else if (!keep) begin
      state <= IDLE;
      timer <= '0;
    end else if (done) begin
      state <= REPEAT;
      timer <= '0;
    end else timer <= timer + 1'b1;
  end
  // count register with registered rollover pulse and end-stop flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap <= 1'b0;
      at_max <= 1'b0;
      at_min <= 1'b1;
    end else begin
      count <= count_nxt;
      wrap <= roll;
      at_max <= &count_nxt;
      at_min <= ~|count_nxt;
    end
  end
endmodule

// File: tb/tb_btn_step_counter.sv
// tb_btn_step_counter: table-driven and sequence checks of wrap and saturate counters
module tb_btn_step_counter;
  typedef struct {
    int btn;
    int on;
    int off;
    int reps;
    int ew;
    int es;
    int dww;
    int dws;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc_r = 1'b1, dec_r = 1'b1, clr_r = 1'b1;
  logic [3:0] cw, cs;
  logic ww, ws, mxw, mnw, mxs, mns;
  int tests = 0, failed = 0;
  int wraps_w = 0, wraps_s = 0, incon = 0;
  vec_t tbl[14];
  vec_t sb[$];
  always #5 clk = ~clk;
  btn_step_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5),
                     .SATURATE(1'b0), .BTN_ACTIVE_LOW(1'b1)) dw (
    .clk(clk), .rst_n(rst_n), .btn_inc(inc_r), .btn_dec(dec_r), .btn_clr(clr_r),
    .count(cw), .wrap(ww), .at_max(mxw), .at_min(mnw)
  );
  btn_step_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5),
                     .SATURATE(1'b1), .BTN_ACTIVE_LOW(1'b1)) ds (
    .clk(clk), .rst_n(rst_n), .btn_inc(inc_r), .btn_dec(dec_r), .btn_clr(clr_r),
    .count(cs), .wrap(ws), .at_max(mxs), .at_min(mns)
  );
  // wrap pulse tally and flag/count consistency monitor
  always @(negedge clk) begin
    wraps_w += int'(ww);
    wraps_s += int'(ws);
    if ((mxw != (cw == 4'hF)) || (mnw != (cw == 4'h0)) || (mxs != (cs == 4'hF)) || (mns != (cs == 4'h0)))
      incon++;
  end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic set_btn(input int b, input bit p);
    if (b == 0) inc_r = ~p;
    else if (b == 1) dec_r = ~p;
    else clr_r = ~p;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int w0, s0, d;
    vec_t e;
    tbl[0]  = '{0, 3, 1, 4, 1, 1, 0, 0};
    tbl[1]  = '{0, 8, 10, 1, 2, 2, 0, 0};
    tbl[2]  = '{1, 8, 10, 1, 1, 1, 0, 0};
    tbl[3]  = '{1, 8, 10, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 8, 10, 1, 15, 0, 1, 0};
    tbl[5]  = '{0, 8, 10, 1, 0, 1, 1, 0};
    tbl[6]  = '{0, 50, 10, 1, 7, 8, 0, 0};
    tbl[7]  = '{0, 8, 10, 7, 14, 15, 0, 0};
    tbl[8]  = '{0, 8, 10, 1, 15, 15, 0, 0};
    tbl[9]  = '{0, 8, 10, 1, 0, 15, 1, 0};
    tbl[10] = '{0, 60, 12, 1, 9, 15, 0, 0};
    tbl[11] = '{1, 100, 12, 1, 8, 0, 1, 0};
    tbl[12] = '{1, 30, 12, 1, 5, 0, 0, 0};
    tbl[13] = '{2, 8, 10, 1, 0, 0, 0, 0};
    cyc(3);
    chk("reset count_w", int'(cw), 0);
    chk("reset wrap_w", int'(ww), 0);
    chk("reset at_min_w", int'(mnw), 1);
    chk("reset at_max_w", int'(mxw), 0);
    chk("reset count_s", int'(cs), 0);
    rst_n = 1'b1;
    cyc(2);
    set_btn(0, 1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) begin
        chk("latency edge6 count", int'(cw), 0);
        chk("latency edge6 at_min", int'(mnw), 1);
      end
      if (i == 7) begin
        chk("latency edge7 count", int'(cw), 1);
        chk("latency edge7 at_min", int'(mnw), 0);
      end
    end
    set_btn(0, 0);
    cyc(12);
    chk("single press final", int'(cw), 1);
    for (int i = 0; i < 14; i++) begin
      sb.push_back(tbl[i]);
      w0 = wraps_w;
      s0 = wraps_s;
      repeat (tbl[i].reps) begin
        set_btn(tbl[i].btn, 1);
        cyc(tbl[i].on);
        set_btn(tbl[i].btn, 0);
        cyc(tbl[i].off);
      end
      cyc(12);
      e = sb.pop_front();
      chk($sformatf("row%0d count_w", i), int'(cw), e.ew);
      chk($sformatf("row%0d at_max_w", i), int'(mxw), int'(e.ew == 15));
      chk($sformatf("row%0d at_min_w", i), int'(mnw), int'(e.ew == 0));
      chk($sformatf("row%0d wraps_w", i), wraps_w - w0, e.dww);
      chk($sformatf("row%0d count_s", i), int'(cs), e.es);
      chk($sformatf("row%0d at_max_s", i), int'(mxs), int'(e.es == 15));
      chk($sformatf("row%0d wraps_s", i), wraps_s - s0, e.dws);
    end
    set_btn(0, 1);
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      d = int'(i >= 7) + int'(i >= 27) + int'(i >= 32) + int'(i >= 37) + int'(i >= 42) + int'(i >= 47) + int'(i >= 52);
      chk($sformatf("hold50 edge%0d", i), int'(cw), d);
      if (i == 50) set_btn(0, 0);
    end
    cyc(10);
    chk("hold50 final", int'(cw), 7);
    set_btn(0, 1);
    cyc(40);
    chk("repeat before clr", int'(cw), 11);
    set_btn(2, 1);
    cyc(20);
    chk("clr in repeat w", int'(cw), 0);
    chk("clr in repeat s", int'(cs), 0);
    cyc(20);
    chk("repeat stopped after clr", int'(cw), 0);
    set_btn(0, 0);
    set_btn(2, 0);
    cyc(12);
    chk("after clr release", int'(cw), 0);
    set_btn(0, 1);
    cyc(10);
    set_btn(1, 1);
    cyc(40);
    chk("inc+dec held no step", int'(cw), 1);
    set_btn(0, 0);
    set_btn(1, 0);
    cyc(12);
    chk("inc+dec release w", int'(cw), 1);
    chk("inc+dec release s", int'(cs), 1);
    set_btn(0, 1);
    cyc(40);
    chk("pre-reset repeat", int'(cw), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset count_w", int'(cw), 0);
    chk("async reset at_min_w", int'(mnw), 1);
    chk("async reset count_s", int'(cs), 0);
    cyc(3);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) chk("post-reset edge6", int'(cw), 0);
      if (i == 7) chk("post-reset edge7", int'(cw), 1);
    end
    set_btn(0, 0);
    cyc(12);
    chk("post-reset final", int'(cw), 1);
    chk("flag consistency", incon, 0);
    chk("saturate never wraps", wraps_s, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
